// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-drain UART transmitter: state encoding, default baud divisor
// and the frame-length helper.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StLoad   = 3'd2,
    StStart  = 3'd3,
    StData   = 3'd4,
    StParity = 3'd5,
    StStop   = 3'd6
  } tx_state_e;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  // Clocks from START entry to STOP exit for one frame.
  function automatic int unsigned frame_clks(input int unsigned clks_per_bit,
                                             input int unsigned parity_en,
                                             input int unsigned stop_bits);
    return (1 + 8 + parity_en + stop_bits) * clks_per_bit;
  endfunction

  localparam int unsigned FRAME_CLKS_DEFAULT = frame_clks(CLKS_PER_BIT_DEFAULT, 0, 1);

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen by a draining consumer: pop strobe out, registered data and empty in.
interface fifo_uart_tx_if;

  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;

  // The consumer issues pops, so it is the master of the read port.
  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_dout
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_dout
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1, flags the last clock of each bit period and
// restarts from zero whenever the controller enters a new state.
module uart_bit_timer
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (restart || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a synchronous FIFO and serialises each as an 8-bit UART frame on txd,
// with optional parity and one or two stop bits; frames run back-to-back while data remains.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  fifo_uart_tx_if.master        fifo,
  output logic                  txd,
  output logic                  busy,
  output logic                  byte_done
);

  if (CLKS_PER_BIT < 4 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 4 and STOP_BITS must be 1 or 2");
  end

  localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

  tx_state_e  state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic       txd_q, txd_d;
  logic       bit_end;
  logic       restart;
  logic       start_ok;

  assign start_ok = tx_en && !fifo.fifo_empty;

  // Any state change reloads the baud counter so every state gets full bit periods.
  assign restart = (state_d != state_q);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    byte_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        state_d = StLoad;
      end
      StLoad: begin
        shift_d  = fifo.fifo_dout;
        parity_d = (^fifo.fifo_dout) ^ (PARITY_ODD != 0);
        state_d  = StStart;
      end
      StStart: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = StStop;
        end
      end
      StStop: begin
        // bit_cnt_q counts stop-bit periods here.
        if (bit_end) begin
          if (bit_cnt_q == LastStop) begin
            byte_done = 1'b1;
            bit_cnt_d = '0;
            state_d   = start_ok ? StFetch : StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // txd is registered from the next state so the line changes on state entry.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
      StParity: txd_d = parity_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      txd_q     <= txd_d;
    end
  end

  assign txd             = txd_q;
  assign busy            = (state_q != StIdle);
  assign fifo.fifo_rd_en = (state_q == StFetch);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at 4 clocks per bit: a FIFO model feeds the main instance,
// and two parity instances (even / odd) run from a directly driven read port.
module tb_fifo_uart_tx;

  localparam int unsigned Cpb = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_en = 1'b1;

  always #5 clk = ~clk;

  fifo_uart_tx_if fif ();
  fifo_uart_tx_if fif_pe ();
  fifo_uart_tx_if fif_po ();

  logic txd0, busy0, byte_done0;
  logic txd1, busy1, byte_done1;
  logic txd2, busy2, byte_done2;

  // FIFO model for the main instance.
  logic [7:0] mem [16];
  int         wr_cnt = 0;
  int         pop_cnt = 0;
  logic [7:0] f_dout = 8'h00;

  assign fif.fifo_empty = (wr_cnt == pop_cnt);
  assign fif.fifo_dout  = f_dout;

  always @(posedge clk) begin
    if (fif.fifo_rd_en && (wr_cnt != pop_cnt)) begin
      f_dout  <= mem[pop_cnt % 16];
      pop_cnt <= pop_cnt + 1;
    end
  end

  logic       par_empty = 1'b1;
  logic [7:0] par_dout = 8'h07;

  assign fif_pe.fifo_empty = par_empty;
  assign fif_pe.fifo_dout  = par_dout;
  assign fif_po.fifo_empty = par_empty;
  assign fif_po.fifo_dout  = par_dout;

  int rd_hi = 0;
  int bd_hi = 0;
  int bad_pop = 0;

  always @(negedge clk) begin
    if (fif.fifo_rd_en) rd_hi++;
    if (byte_done0) bd_hi++;
    if (fif.fifo_rd_en && fif.fifo_empty) bad_pop++;
  end

  fifo_uart_tx #(
    .CLKS_PER_BIT (Cpb),
    .PARITY_EN    (0),
    .PARITY_ODD   (0),
    .STOP_BITS    (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (tx_en),
    .fifo      (fif),
    .txd       (txd0),
    .busy      (busy0),
    .byte_done (byte_done0)
  );

  fifo_uart_tx #(
    .CLKS_PER_BIT (Cpb),
    .PARITY_EN    (1),
    .PARITY_ODD   (0),
    .STOP_BITS    (1)
  ) dut_pe (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (1'b1),
    .fifo      (fif_pe),
    .txd       (txd1),
    .busy      (busy1),
    .byte_done (byte_done1)
  );

  fifo_uart_tx #(
    .CLKS_PER_BIT (Cpb),
    .PARITY_EN    (1),
    .PARITY_ODD   (1),
    .STOP_BITS    (1)
  ) dut_po (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (1'b1),
    .fifo      (fif_po),
    .txd       (txd2),
    .busy      (busy2),
    .byte_done (byte_done2)
  );

  int n_checks = 0;
  int n_pass = 0;

  logic [63:0] tr_txd [3];
  logic [63:0] tr_bd [3];

  task automatic push(input logic [7:0] b);
    mem[wr_cnt % 16] = b;
    wr_cnt++;
  endtask

  function automatic logic sel_txd(input int s);
    return (s == 0) ? txd0 : ((s == 1) ? txd1 : txd2);
  endfunction

  // Expected txd per clock, starting at the first START clock.
  function automatic logic [63:0] frame_bits(input logic [7:0] b, input bit par_en,
                                             input logic par_bit);
    logic [10:0] bits;
    logic [63:0] r;
    int          nb;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    if (par_en) bits[9] = par_bit;
    nb = par_en ? 11 : 10;
    r  = '0;
    for (int j = 0; j < nb; j++) begin
      for (int c = 0; c < 4; c++) r[j * 4 + c] = bits[j];
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_bd(input int len);
    return 64'(1) << (len - 1);
  endfunction

  // Waits (bounded) for the selected txd to fall, then records len clocks of all instances.
  task automatic capture(input int sel, input int len, input int drop_idx,
                         output int wait_n, output bit found);
    wait_n = 0;
    found  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tr_txd[k] = '0;
      tr_bd[k]  = '0;
    end
    while (!found && wait_n < 200) begin
      if (sel_txd(sel) == 1'b0) found = 1'b1;
      else begin
        @(negedge clk);
        wait_n++;
      end
    end
    if (!found) begin
      n_checks++;
      $display("FAIL capture_timeout: txd of instance %0d still high after %0d clks, required low",
               sel, wait_n);
      return;
    end
    for (int i = 0; i < len; i++) begin
      tr_txd[0][i] = txd0;
      tr_txd[1][i] = txd1;
      tr_txd[2][i] = txd2;
      tr_bd[0][i]  = byte_done0;
      tr_bd[1][i]  = byte_done1;
      tr_bd[2][i]  = byte_done2;
      if (i == drop_idx) tx_en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    push(8'hA5);
    rst   = 1'b1;
    tx_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (txd0 !== 1'b1) $display("FAIL reset_txd clk%0d: got %b want 1", c, txd0);
      else n_pass++;
      n_checks++;
      if (fif.fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en clk%0d: got %b want 0", c,
                                            fif.fifo_rd_en);
      else n_pass++;
      n_checks++;
      if (busy0 !== 1'b0) $display("FAIL reset_busy clk%0d: got %b want 0", c, busy0);
      else n_pass++;
      n_checks++;
      if (byte_done0 !== 1'b0) $display("FAIL reset_byte_done clk%0d: got %b want 0", c,
                                        byte_done0);
      else n_pass++;
    end
  endtask

  task automatic test_single_frame();
    int w;
    bit f;
    int rd0, bdc0;
    rst  = 1'b0;
    rd0  = rd_hi;
    bdc0 = bd_hi;
    capture(0, 40, -1, w, f);
    n_checks++;
    if (w !== 3) $display("FAIL single_latency: txd fell after %0d clks want 3", w);
    else n_pass++;
    n_checks++;
    if (tr_txd[0] !== frame_bits(8'hA5, 1'b0, 1'b0))
      $display("FAIL single_txd: got %h want %h", tr_txd[0], frame_bits(8'hA5, 1'b0, 1'b0));
    else n_pass++;
    n_checks++;
    if (tr_bd[0] !== exp_bd(40)) $display("FAIL single_byte_done: got %h want %h", tr_bd[0],
                                          exp_bd(40));
    else n_pass++;
    n_checks++;
    if (rd_hi - rd0 !== 1) $display("FAIL single_rd_en_clks: got %0d want 1", rd_hi - rd0);
    else n_pass++;
    n_checks++;
    if (bd_hi - bdc0 !== 1) $display("FAIL single_byte_done_count: got %0d want 1", bd_hi - bdc0);
    else n_pass++;
    n_checks++;
    if (busy0 !== 1'b0) $display("FAIL single_busy_after: got %b want 0", busy0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int w;
    bit f;
    int rd0, bdc0;
    bytes = '{8'h00, 8'hFF, 8'h55};
    rd0   = rd_hi;
    bdc0  = bd_hi;
    for (int k = 0; k < 3; k++) push(bytes[k]);
    for (int k = 0; k < 3; k++) begin
      capture(0, 40, -1, w, f);
      n_checks++;
      if (w !== ((k == 0) ? 3 : 2))
        $display("FAIL b2b_gap frame%0d: high clks before start %0d want %0d", k, w,
                 (k == 0) ? 3 : 2);
      else n_pass++;
      n_checks++;
      if (tr_txd[0] !== frame_bits(bytes[k], 1'b0, 1'b0))
        $display("FAIL b2b_txd frame%0d: got %h want %h", k, tr_txd[0],
                 frame_bits(bytes[k], 1'b0, 1'b0));
      else n_pass++;
      n_checks++;
      if (tr_bd[0] !== exp_bd(40))
        $display("FAIL b2b_byte_done frame%0d: got %h want %h", k, tr_bd[0], exp_bd(40));
      else n_pass++;
    end
    n_checks++;
    if (rd_hi - rd0 !== 3) $display("FAIL b2b_rd_en_clks: got %0d want 3", rd_hi - rd0);
    else n_pass++;
    n_checks++;
    if (bd_hi - bdc0 !== 3) $display("FAIL b2b_byte_done_count: got %0d want 3", bd_hi - bdc0);
    else n_pass++;
    n_checks++;
    if (busy0 !== 1'b0) $display("FAIL b2b_busy_after: got %b want 0", busy0);
    else n_pass++;
  endtask

  task automatic test_parity();
    int w;
    int n;
    bit f;
    par_empty = 1'b0;
    n = 0;
    while (fif_pe.fifo_rd_en !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    par_empty = 1'b1;
    n_checks++;
    if (fif_pe.fifo_rd_en !== 1'b1) $display("FAIL parity_fetch: rd_en %b want 1 within 10 clks",
                                             fif_pe.fifo_rd_en);
    else n_pass++;
    capture(1, 44, -1, w, f);
    // 0x07 has three ones: even sense sends 1, odd sense sends 0.
    n_checks++;
    if (tr_txd[1] !== frame_bits(8'h07, 1'b1, 1'b1))
      $display("FAIL parity_even_txd: got %h want %h", tr_txd[1], frame_bits(8'h07, 1'b1, 1'b1));
    else n_pass++;
    n_checks++;
    if (tr_txd[2] !== frame_bits(8'h07, 1'b1, 1'b0))
      $display("FAIL parity_odd_txd: got %h want %h", tr_txd[2], frame_bits(8'h07, 1'b1, 1'b0));
    else n_pass++;
    n_checks++;
    if (tr_bd[1] !== exp_bd(44)) $display("FAIL parity_even_len: got %h want %h", tr_bd[1],
                                          exp_bd(44));
    else n_pass++;
    n_checks++;
    if (tr_bd[2] !== exp_bd(44)) $display("FAIL parity_odd_len: got %h want %h", tr_bd[2],
                                          exp_bd(44));
    else n_pass++;
    n_checks++;
    if (busy1 !== 1'b0) $display("FAIL parity_busy_after: got %b want 0", busy1);
    else n_pass++;
  endtask

  task automatic test_tx_en_drop();
    int w;
    bit f;
    int rd0;
    rd0   = rd_hi;
    tx_en = 1'b1;
    push(8'h3C);
    push(8'h81);
    capture(0, 40, 14, w, f);
    n_checks++;
    if (tr_txd[0] !== frame_bits(8'h3C, 1'b0, 1'b0))
      $display("FAIL drop_txd: got %h want %h", tr_txd[0], frame_bits(8'h3C, 1'b0, 1'b0));
    else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++;
    if (rd_hi - rd0 !== 1) $display("FAIL drop_no_fetch: rd_en clks %0d want 1", rd_hi - rd0);
    else n_pass++;
    n_checks++;
    if (busy0 !== 1'b0) $display("FAIL drop_busy: got %b want 0", busy0);
    else n_pass++;
    n_checks++;
    if (wr_cnt - pop_cnt !== 1) $display("FAIL drop_fifo_level: got %0d want 1", wr_cnt - pop_cnt);
    else n_pass++;
    tx_en = 1'b1;
    capture(0, 40, -1, w, f);
    n_checks++;
    if (w !== 3) $display("FAIL resume_latency: got %0d want 3", w);
    else n_pass++;
    n_checks++;
    if (tr_txd[0] !== frame_bits(8'h81, 1'b0, 1'b0))
      $display("FAIL resume_txd: got %h want %h", tr_txd[0], frame_bits(8'h81, 1'b0, 1'b0));
    else n_pass++;
    n_checks++;
    if (rd_hi - rd0 !== 2) $display("FAIL resume_rd_en_clks: got %0d want 2", rd_hi - rd0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int lows;
    int rd0;
    push(8'h5A);
    n = 0;
    while (txd0 !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (txd0 !== 1'b0) $display("FAIL midrst_start: txd %b want 0 within 20 clks", txd0);
    else n_pass++;
    // Index 17 from the first START clock lies inside data bit 3.
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (txd0 !== 1'b1) $display("FAIL midrst_txd: got %b want 1", txd0);
    else n_pass++;
    n_checks++;
    if (busy0 !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy0);
    else n_pass++;
    @(negedge clk);
    rst  = 1'b0;
    rd0  = rd_hi;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd0 !== 1'b1) lows++;
    end
    n_checks++;
    if (rd_hi - rd0 !== 0) $display("FAIL midrst_no_reread: rd_en clks %0d want 0", rd_hi - rd0);
    else n_pass++;
    n_checks++;
    if (lows !== 0) $display("FAIL midrst_line_idle: low clks %0d want 0", lows);
    else n_pass++;
    n_checks++;
    if (bad_pop !== 0) $display("FAIL empty_pop: pops while empty %0d want 0", bad_pop);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity();
    test_tx_en_drop();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded 40000 clks, required to finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
